clb_slice: RTL and testbench
============================

CLB_SLICE -- requirements
Module: clb_slice

Interface
REQ-001 SHALL have parameter K, default 4, LUT inputs per element (2..6).
REQ-002 SHALL have parameter N, default 2, logic elements per slice (1..8); local CW = 2^K+5 bits per element, CFG_W = N*CW.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  serial config bit valid.
REQ-006 SHALL have port cfg_data  input  1  serial config bit.
REQ-007 SHALL have port cfg_ready  output  1  loader accepts a bit this cycle.
REQ-008 SHALL have port cfg_restart  input  1  pulse; discards config, reopens loading.
REQ-009 SHALL have port cfg_done  output  1  slice configured and running.
REQ-010 SHALL have port ce  input  1  flip-flop clock enable.
REQ-011 SHALL have port in  input  N*K  element i uses in[i*K+K-1:i*K]; bit i*K is generate input a_i, bit i*K+1 is b_i.
REQ-012 SHALL have port carry_in  input  1  slice carry input.
REQ-013 SHALL have port out  output  N  element outputs.
REQ-014 SHALL have port carry_out  output  1  carry from element N-1.

Function
REQ-015 Per-element config field at base i*CW: [2^K-1:0] LUT truth table (index = element inputs), [2^K] out_sel (1 = registered), [2^K+1] carry_en, [2^K+2] ff_init, [2^K+4:2^K+3] cin_sel (element 0 only; ignored for i>0).
REQ-016 FSM states SHALL be UNCFG, LOAD, RUN; cfg_ready=1 in UNCFG and LOAD, 0 in RUN; cfg_done=1 only in RUN.
REQ-017 A bit SHALL be accepted when cfg_valid&cfg_ready: shift register shifts left, cfg_data enters LSB, so the first accepted bit ends at CFG_W-1; bit counter increments; UNCFG moves to LOAD on first accept.
REQ-018 cfg_valid gaps SHALL stall loading without loss; counter and shift register hold.
REQ-019 On the CFG_W-th accept the FSM SHALL enter RUN at that edge: config register <= final shift contents, every FF <= its ff_init, counter cleared; cfg_done=1 from the next cycle.
REQ-020 cfg_restart in RUN SHALL move to LOAD next edge, clear counter, drop cfg_done; cfg_restart in UNCFG/LOAD SHALL clear the counter and shift register (simultaneous accepted bit discarded).
REQ-021 Outside RUN, out and carry_out SHALL be 0 and FFs SHALL hold.
REQ-022 Carry chain (combinational): c_0 = carry_in (cin_sel 00), 0 (01), 1 (10/11); p_i = LUT_i; c_{i+1} = p_i ? c_i : a_i; carry_out = c_N.
REQ-023 d_i = carry_en ? (p_i XOR c_i) : p_i; element with carry_en=0 still propagates c_{i+1} per REQ-022.
REQ-024 In RUN with ce=1, FF_i <= d_i each edge; ce=0 holds.
REQ-025 out[i] = out_sel ? FF_i : d_i; combinational path zero-latency, registered path one cycle.

Reset
REQ-026 reset low SHALL immediately force UNCFG, counter 0, shift and config registers 0, FFs 0, out 0, carry_out 0, cfg_done 0, cfg_ready 1, regardless of clk, including mid-load.
REQ-027 After reset release a full CFG_W-bit load SHALL be required before cfg_done rises.

Verification (K=4, N=2, CFG_W=42)
V1 reset pulse low mid-cycle -> out=00, carry_out=0, cfg_done=0, cfg_ready=1 asynchronously.
V2 load LUT=0x8000, out_sel=0, carry_en=0 both elements, 42 bits with random valid gaps -> cfg_done=1 cycle after 42nd accept; in=8'hFF -> out=11; in=8'h7F -> out=01.
V3 LUT=0x6666 (a XOR b), carry_en=1, cin_sel=00; a=11, b=01, carry_in=0 -> out=00, carry_out=1; carry_in=1 -> out=01, carry_out=1.
V4 out_sel=1, ff_init=1, LUT=0x0000 -> out=11 right after config; ce=0 for 3 cycles -> out=11; ce=1 -> out=00 after one edge.
V5 reset low after 20 accepted bits, then 42 new bits -> config matches only the new stream; cfg_done never rises before bit 42.
V6 cfg_restart in RUN -> next cycle out=00, carry_out=0, cfg_done=0, cfg_ready=1; reload of V3 config restores V3 results.

Source files
------------

// File: rtl/clb_slice.sv
// clb_slice: N-element K-input LUT slice with carry chain, per-element FF and bit-serial config loader
module clb_slice #(
  parameter int K = 4,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  input  logic         cfg_data,
  output logic         cfg_ready,
  input  logic         cfg_restart,
  output logic         cfg_done,
  input  logic         ce,
  input  logic [N*K-1:0] in,
  input  logic         carry_in,
  output logic [N-1:0] out,
  output logic         carry_out
);
  localparam int L = 2**K;
  localparam int CW = L + 5;
  localparam int CFG_W = N*CW;
  localparam int CNT_W = $clog2(CFG_W + 1);
  typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;
  state_t state;
  logic [CFG_W-1:0] sr, cfg, nsr;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0] ff, p, d, o;
  logic [N:0] c;
  logic [1:0] cs;
  logic run, accept, last;
  assign run = state == RUN;
  assign cfg_ready = !run;
  assign cfg_done = run;
  assign accept = cfg_valid & cfg_ready;
  assign nsr = {sr[CFG_W-2:0], cfg_data};
  assign last = cnt == CNT_W'(CFG_W - 1);
  assign cs = cfg[L+4:L+3];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= UNCFG;
      cnt <= '0;
      sr <= '0;
      cfg <= '0;
      ff <= '0;
    end else if (run) begin
      if (cfg_restart) begin
        state <= LOAD;
        cnt <= '0;
      end else if (ce) ff <= d;
    end else if (cfg_restart) begin
      cnt <= '0;
      sr <= '0;
    end else if (accept) begin
      sr <= nsr;
      cnt <= last ? '0 : cnt + 1'b1;
      state <= last ? RUN : LOAD;
      if (last) begin
        cfg <= nsr;
        for (int i = 0; i < N; i++) ff[i] <= nsr[i*CW+L+2];
      end
    end
  always_comb begin
    c = '0;
    p = '0;
    d = '0;
    o = '0;
    c[0] = cs == 2'b00 ? carry_in : cs[1];
    for (int i = 0; i < N; i++) begin
      p[i] = cfg[i*CW + int'(in[i*K +: K])];
      c[i+1] = p[i] ? c[i] : in[i*K];
      d[i] = cfg[i*CW+L+1] ? p[i] ^ c[i] : p[i];
      o[i] = cfg[i*CW+L] ? ff[i] : d[i];
    end
  end
  assign out = run ? o : '0;
  assign carry_out = run & c[N];
endmodule

// File: tb/tb_clb_slice.sv
// tb_clb_slice: scoreboard bench for clb_slice (K=4, N=2, 42 config bits)
module tb_clb_slice;
  logic clk = 0, reset = 0, cfg_valid = 0, cfg_data = 0, cfg_restart = 0, ce = 0, carry_in = 0;
  logic [7:0] in = '0;
  logic cfg_ready, cfg_done, carry_out;
  logic [1:0] out;
  int n_cmp = 0, n_bad = 0;
  typedef struct {string tag; logic [2:0] exp;} item_t;
  item_t sb[$];
  logic [41:0] cfg2, cfg3, cfg4;
  clb_slice #(.K(4), .N(2)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_restart(cfg_restart), .cfg_done(cfg_done),
    .ce(ce), .in(in), .carry_in(carry_in), .out(out), .carry_out(carry_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [20:0] elem(logic [15:0] lut, logic os, logic cen, logic init, logic [1:0] cs);
    return {cs, init, cen, os, lut};
  endfunction
  task automatic push(input string tag, input logic [2:0] e);
    item_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask
  task automatic pop_cmp();
    item_t it;
    it = sb.pop_front();
    check(it.tag, {carry_out, out}, it.exp);
  endtask
  task automatic vec(input string tag, input logic [7:0] v, input logic ci, input logic [2:0] e);
    @(negedge clk);
    in = v;
    carry_in = ci;
    push(tag, e);
    #1 pop_cmp();
  endtask
  task automatic load(input logic [41:0] v, input int n);
    for (int b = 41; b > 41 - n; b--) begin
      @(negedge clk);
      while ($urandom_range(0, 2) == 0) begin
        cfg_valid = 0;
        @(negedge clk);
      end
      check("done_early", cfg_done, 0);
      cfg_valid = 1;
      cfg_data = v[b];
    end
    @(negedge clk);
    cfg_valid = 0;
    if (n == 42) check("done_after_load", cfg_done, 1);
    else check("ready_midload", cfg_ready, 1);
  endtask
  task automatic restart();
    @(negedge clk);
    cfg_restart = 1;
    @(negedge clk);
    cfg_restart = 0;
    push("restart_out", 3'b000);
    #1 pop_cmp();
    check("restart_done", cfg_done, 0);
    check("restart_ready", cfg_ready, 1);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2 reset = 0;
    push("rst_out", 3'b000);
    #1 pop_cmp();
    check("rst_done", cfg_done, 0);
    check("rst_ready", cfg_ready, 1);
    @(negedge clk);
    reset = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end
  initial begin
    cfg2 = {elem(16'h8000, 0, 0, 0, 2'b00), elem(16'h8000, 0, 0, 0, 2'b00)};
    cfg3 = {elem(16'h6666, 0, 1, 0, 2'b00), elem(16'h6666, 0, 1, 0, 2'b00)};
    cfg4 = {elem(16'h0000, 1, 0, 1, 2'b00), elem(16'h0000, 1, 0, 1, 2'b00)};
    in = 8'hFF;
    #1;
    push("reset_state", 3'b000);
    pop_cmp();
    check("reset_ready", cfg_ready, 1);
    check("reset_done", cfg_done, 0);
    @(negedge clk);
    reset = 1;
    load(cfg2, 42);
    vec("and_ff", 8'hFF, 0, 3'b0_11);
    vec("and_7f", 8'h7F, 0, 3'b1_01);
    in = 8'hFF;
    async_reset();
    vec("uncfg_out", 8'hFF, 1, 3'b000);
    check("uncfg_done", cfg_done, 0);
    load(cfg3, 42);
    vec("xor_ci0", 8'h13, 0, 3'b1_00);
    vec("xor_ci1", 8'h13, 1, 3'b1_01);
    restart();
    load(cfg3, 42);
    vec("reload_ci0", 8'h13, 0, 3'b1_00);
    vec("reload_ci1", 8'h13, 1, 3'b1_01);
    restart();
    load(cfg4, 20);
    async_reset();
    load(cfg2, 42);
    vec("new_ff", 8'hFF, 0, 3'b0_11);
    vec("new_7f", 8'h7F, 0, 3'b1_01);
    restart();
    load(cfg4, 42);
    vec("ffinit", 8'h00, 0, 3'b0_11);
    for (int i = 0; i < 3; i++) vec("ce_hold", 8'h00, 0, 3'b0_11);
    @(negedge clk);
    ce = 1;
    vec("ce_load", 8'h00, 0, 3'b0_00);
    ce = 0;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
